// File: rtl/key_debounce_pkg.sv
// Shared state encoding and synchroniser depth for the key debounce bank.
package key_debounce_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_FILTER_DN = 4'b0010,
        S_DOWN      = 4'b0100,
        S_FILTER_UP = 4'b1000
    } state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, polarity normalise, debounce FSM, press/release/long pulses.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_down_o,
    output logic key_up_o,
    output logic key_long_o
);

    localparam int MAX_CYC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2) begin : g_deb_chk
        $error("key_debounce_ch: DEB_CYCLES must be >= 2");
    end

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  pressed;
    state_t                state_q, state_d;
    logic [CW-1:0]         deb_cnt_q, deb_cnt_d;
    logic                  down_q, down_d, up_q, up_d;

    // Reset to the idle level so leaving reset with keys released is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_DEPTH{IDLE_LVL}};
        else        sync_q <= {sync_q[SYNC_DEPTH-2:0], key_raw_i};
    end

    assign pressed = sync_q[SYNC_DEPTH-1] ^ IDLE_LVL;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        down_d    = 1'b0;
        up_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                deb_cnt_d = '0;
                if (pressed) state_d = S_FILTER_DN;
            end
            S_FILTER_DN: begin
                if (!pressed) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_TC) begin
                    state_d   = S_DOWN;
                    deb_cnt_d = '0;
                    down_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            S_DOWN: begin
                deb_cnt_d = '0;
                if (!pressed) state_d = S_FILTER_UP;
            end
            S_FILTER_UP: begin
                if (pressed) begin
                    state_d   = S_DOWN;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_TC) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                    up_d      = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            deb_cnt_q <= '0;
            down_q    <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            down_q    <= down_d;
            up_q      <= up_d;
        end
    end

    assign key_level_o = (state_q == S_DOWN) || (state_q == S_FILTER_UP);
    assign key_down_o  = down_q;
    assign key_up_o    = up_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_SAT = CW'(HOLD_CYCLES);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_q, long_d;

    // Counts only while in DOWN, frozen through release bounce, saturates so it fires once.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (state_q == S_IDLE) begin
            hold_cnt_d = '0;
        end else if (state_q == S_DOWN && hold_cnt_q != HOLD_SAT) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
            long_d     = (hold_cnt_q == HOLD_TC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    assign key_long_o = long_q;
`else
    assign key_long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N_CH independent debounced keys; wiring only, one key_debounce_ch per channel.
// Optional long-press pulses: define KEY_LONG_PRESS_EN.
module key_debounce_bank #(
    parameter int N_CH        = 4,
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] key_raw,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_down,
    output logic [N_CH-1:0] key_up,
    output logic [N_CH-1:0] key_long
);

    if (N_CH < 1 || N_CH > 32) begin : g_nch_chk
        $error("key_debounce_bank: N_CH must be 1..32");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw_i  (key_raw[i]),
            .key_level_o(key_level[i]),
            .key_down_o (key_down[i]),
            .key_up_o   (key_up[i]),
            .key_long_o (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank (N_CH=4, DEB_CYCLES=8, HOLD_CYCLES=40, active-low keys).
module tb_key_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key_raw = 4'hF;
    logic [3:0] key_level, key_down, key_up, key_long;

    key_debounce_bank #(
        .N_CH(4), .DEB_CYCLES(8), .HOLD_CYCLES(40), .ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (key_raw),
        .key_level(key_level),
        .key_down (key_down),
        .key_up   (key_up),
        .key_long (key_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] dn;
        logic [3:0] up;
        logic [3:0] lg;
    } ev_t;

    ev_t q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic push(input int c, input logic [3:0] dn, input logic [3:0] up, input logic [3:0] lg);
        ev_t e;
        e.cyc = c; e.dn = dn; e.up = up; e.lg = lg;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if ((key_down | key_up | key_long) != 4'b0) begin
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse: cyc=%0d dn=%b up=%b lg=%b, expected none",
                         cyc, key_down, key_up, key_long);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc == cyc && e.dn === key_down && e.up === key_up && e.lg === key_long)
                    n_pass++;
                else
                    $display("FAIL event: got cyc=%0d dn=%b up=%b lg=%b, expected cyc=%0d dn=%b up=%b lg=%b",
                             cyc, key_down, key_up, key_long, e.cyc, e.dn, e.up, e.lg);
            end
        end
    end

    initial begin
        int c0, g0, p0, b0, s0, l0, r0, r1, rq;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_level", key_level, 4'b0);
        chk("reset_down",  key_down,  4'b0);
        chk("reset_up",    key_up,    4'b0);
        chk("reset_long",  key_long,  4'b0);
        goto(3);
        rst_n = 1'b1;
        goto(10);

        // Clean press and release on channel 0.
        c0 = cyc;
        key_raw[0] = 1'b0;
        push(c0 + 11, 4'b0001, 4'b0000, 4'b0000);
        goto(c0 + 10);
        chk("press_level_before", {31'b0, key_level[0]}, 32'd0);
        goto(c0 + 12);
        chk("press_level_after", {31'b0, key_level[0]}, 32'd1);
        goto(c0 + 20);
        key_raw[0] = 1'b1;
        push(c0 + 31, 4'b0000, 4'b0001, 4'b0000);
        goto(c0 + 40);
        chk("release_level", {31'b0, key_level[0]}, 32'd0);

        // Short glitch on channel 1 must be rejected.
        g0 = cyc;
        key_raw[1] = 1'b0;
        goto(g0 + 5);
        key_raw[1] = 1'b1;
        goto(g0 + 6);
        chk("glitch_level_mid", {31'b0, key_level[1]}, 32'd0);
        goto(g0 + 25);
        chk("glitch_level_end", {31'b0, key_level[1]}, 32'd0);

        // Release bounce on channel 2: one key_up after the final rise.
        p0 = cyc;
        key_raw[2] = 1'b0;
        push(p0 + 11, 4'b0100, 4'b0000, 4'b0000);
        goto(p0 + 14);
        b0 = cyc;
        for (int i = 0; i < 7; i++) begin
            goto(b0 + 3 * i);
            key_raw[2] = (i % 2 == 0);
        end
        push(b0 + 29, 4'b0000, 4'b0100, 4'b0000);
        goto(b0 + 27);
        chk("bounce_level_held", {31'b0, key_level[2]}, 32'd1);
        goto(b0 + 40);

        // All channels pressed and released together.
        s0 = cyc;
        key_raw = 4'h0;
        push(s0 + 11, 4'b1111, 4'b0000, 4'b0000);
        goto(s0 + 13);
        chk("simul_level", key_level, 4'b1111);
        goto(s0 + 16);
        key_raw = 4'hF;
        push(s0 + 27, 4'b0000, 4'b1111, 4'b0000);
        goto(s0 + 35);

        // Long hold on channel 2.
        l0 = cyc;
        key_raw[2] = 1'b0;
        push(l0 + 11, 4'b0100, 4'b0000, 4'b0000);
`ifdef KEY_LONG_PRESS_EN
        push(l0 + 51, 4'b0000, 4'b0000, 4'b0100);
`endif
        goto(l0 + 60);
        chk("long_level", {31'b0, key_level[2]}, 32'd1);
        goto(l0 + 80);
        key_raw[2] = 1'b1;
        push(l0 + 91, 4'b0000, 4'b0100, 4'b0000);
        goto(l0 + 100);

        // Reset during FILTER_DN of channel 0 while channel 3 is already down.
        r0 = cyc;
        key_raw[3] = 1'b0;
        push(r0 + 11, 4'b1000, 4'b0000, 4'b0000);
        goto(r0 + 13);
        chk("pre_reset_level", key_level, 4'b1000);
        r1 = cyc;
        key_raw[0] = 1'b0;
        goto(r1 + 9);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", key_level, 4'b0);
        chk("midrst_down",  key_down,  4'b0);
        chk("midrst_up",    key_up,    4'b0);
        chk("midrst_long",  key_long,  4'b0);
        goto(r1 + 11);
        rst_n = 1'b1;
        rq = cyc;
        push(rq + 11, 4'b1001, 4'b0000, 4'b0000);
        goto(rq + 10);
        chk("postrst_level_before", key_level, 4'b0);
        goto(rq + 15);
        chk("postrst_level_after", key_level, 4'b1001);
        key_raw = 4'hF;
        push(rq + 26, 4'b0000, 4'b1001, 4'b0000);
        goto(rq + 40);

        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
